uart_tx_fifo: RTL

Transmit-side counterpart of the UART receive path: bytes written by the host are buffered in a FIFO and serialized onto `tx` as 8N1 frames (optionally 8E1), one bit per `baud_tick`. It shares the same `baud_tick` source as the receiver and presents a write/full handshake to the host.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_tx_serializer.sv | 134 +++++++++++++
 rtl/uart_tx_fifo.sv | 88 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
// When UART_TX_PARITY_EN is defined, the state enumeration includes PARITY.
`timescale 1ns/1ps
package uart_pkg;

    localparam int   UART_DATA_BITS   = 8;
    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;
    localparam logic UART_STOP_LEVEL  = 1'b1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } uart_state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3
    } uart_state_t;
`endif

endpackage

// File: rtl/uart_tx_serializer.sv
// Frame serializer: pops one byte from the FIFO head and shifts it onto tx,
// one line level per baud_tick, LSB first. When UART_TX_PARITY_EN is defined,
// an even-parity bit is inserted between the data bits and the stop bit.
// The current FSM state is exported on 'state' for debug and for tx_busy.
`timescale 1ns/1ps
module uart_tx_serializer
    import uart_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      baud_tick,
    input  logic                      fifo_empty,
    input  logic [UART_DATA_BITS-1:0] head_data,
    output logic                      pop,
    output logic                      tx,
    output uart_state_t               state
);

    localparam int              CNT_W    = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(UART_DATA_BITS - 1);

    uart_state_t               state_next;
    logic [UART_DATA_BITS-1:0] shift_reg;
    logic [UART_DATA_BITS-1:0] shift_next;
    logic [CNT_W-1:0]          bit_cnt;
    logic [CNT_W-1:0]          cnt_next;
    logic                      tx_next;
`ifdef UART_TX_PARITY_EN
    logic                      parity_bit;
    logic                      parity_next;
`endif

    // State, shift register, bit counter and the registered line level.
    // Reset forces the line idle at once, aborting any frame in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            tx         <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            shift_reg  <= shift_next;
            bit_cnt    <= cnt_next;
            tx         <= tx_next;
`ifdef UART_TX_PARITY_EN
            parity_bit <= parity_next;
`endif
        end
    end

    // Next-state and next line level; every transition waits for baud_tick,
    // so tx only ever changes in the cycle after a tick.
    always_comb begin
        state_next  = state;
        shift_next  = shift_reg;
        cnt_next    = bit_cnt;
        tx_next     = tx;
        pop         = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next = parity_bit;
`endif
        case (state)
            IDLE: begin
                tx_next = UART_IDLE_LEVEL;
                if (baud_tick && !fifo_empty) begin
                    pop = 1'b1;
                end
            end
            START: begin
                if (baud_tick) begin
                    tx_next    = shift_reg[0];
                    shift_next = {1'b0, shift_reg[UART_DATA_BITS-1:1]};
                    cnt_next   = '0;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        tx_next    = parity_bit;
                        state_next = PARITY;
`else
                        tx_next    = UART_STOP_LEVEL;
                        state_next = STOP;
`endif
                    end else begin
                        tx_next    = shift_reg[0];
                        shift_next = {1'b0, shift_reg[UART_DATA_BITS-1:1]};
                        cnt_next   = bit_cnt + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_tick) begin
                    tx_next    = UART_STOP_LEVEL;
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_tick) begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        tx_next    = UART_IDLE_LEVEL;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                tx_next    = UART_IDLE_LEVEL;
                state_next = IDLE;
            end
        endcase

        // A pop (from IDLE or back-to-back from STOP) loads the next frame.
        if (pop) begin
            shift_next  = head_data;
            cnt_next    = '0;
            tx_next     = UART_START_LEVEL;
            state_next  = START;
`ifdef UART_TX_PARITY_EN
            parity_next = ^head_data;
`endif
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit path: host-side byte FIFO feeding the frame serializer.
// Frame format is 8N1 by default; define UART_TX_PARITY_EN for 8E1.
// Host handshake: tx_write acts as valid and !tx_full as ready; a byte is
// accepted on any rising clk edge where both are high. A write while full
// is dropped and reported by a one-cycle tx_overflow pulse on the next cycle.
`timescale 1ns/1ps
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       baud_tick,
    input  logic [DATA_WIDTH-1:0]      tx_data_in,
    input  logic                       tx_write,
    output logic                       tx_full,
    output logic                       tx_empty,
    output logic [$clog2(DEPTH+1)-1:0] tx_count,
    output logic                       tx_overflow,
    output logic                       tx_busy,
    output logic                       tx
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  wr_en;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head_data;
    uart_state_t           ser_state;

    // Flags come from the registered count, so a same-cycle pop never
    // frees room for that cycle's write.
    assign tx_full   = (count == CW'(DEPTH));
    assign tx_empty  = (count == '0);
    assign tx_count  = count;
    assign wr_en     = tx_write && !tx_full;
    assign head_data = mem[rd_ptr];
    assign tx_busy   = (ser_state != IDLE);

    // Storage array; contents are left as-is on reset, the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= tx_data_in;
        end
    end

    // Pointers wrap naturally; count tracks push-only/pop-only, holds on both.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            tx_overflow <= 1'b0;
        end else begin
            tx_overflow <= tx_write && tx_full;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    uart_tx_serializer u_serializer (
        .clk        (clk),
        .reset      (reset),
        .baud_tick  (baud_tick),
        .fifo_empty (tx_empty),
        .head_data  (head_data),
        .pop        (pop),
        .tx         (tx),
        .state      (ser_state)
    );

endmodule
